// File: rtl/ss_pkg.sv
// ----------------------------------------------------------------------------
// ss_pkg
// Shared definitions for the stalled single-store kernel:
//   - default RAM geometry (word width, address width)
//   - default kernel source/destination addresses
//   - kernel FSM state encoding
// ----------------------------------------------------------------------------
package ss_pkg;

   localparam int unsigned DATA_W_DEF   = 32;
   localparam int unsigned ADDR_W_DEF   = 5;
   localparam int unsigned SRC_ADDR_DEF = 1;
   localparam int unsigned DST_ADDR_DEF = 0;

   typedef enum logic [2:0] {
      S_READ,
      S_WAIT,
      S_WRITE,
      S_DONE,
      S_HALT
   } state_t;

endpackage

// File: rtl/ss_ram.sv
// ----------------------------------------------------------------------------
// ss_ram
// 1R1W RAM with an extra debug write port and a combinational debug read port.
// Contents are never reset.
// Ports:
//   clk          in   clock, all writes and the kernel read on posedge
//   i_ren        in   kernel read issue
//   i_raddr      in   kernel read address
//   o_rdata      out  registered kernel read data (holds until next read issue)
//   i_wen        in   kernel write strobe
//   i_waddr      in   kernel write address
//   i_wdata      in   kernel write data
//   i_dbg_raddr  in   debug read address
//   o_dbg_rdata  out  mem[i_dbg_raddr], combinational
//   i_dbg_wen    in   debug write strobe
//   i_dbg_waddr  in   debug write address
//   i_dbg_wdata  in   debug write data
// ----------------------------------------------------------------------------
module ss_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              i_ren,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata,
   input  logic              i_wen,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_dbg_raddr,
   output logic [DATA_W-1:0] o_dbg_rdata,
   input  logic              i_dbg_wen,
   input  logic [ADDR_W-1:0] i_dbg_waddr,
   input  logic [DATA_W-1:0] i_dbg_wdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Debug write is placed after the kernel write so it wins a same-address
   // collision.
   always_ff @(posedge clk) begin
      if (i_wen)
         r_mem[i_waddr] <= i_wdata;
      if (i_dbg_wen)
         r_mem[i_dbg_waddr] <= i_dbg_wdata;
      if (i_ren)
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata     = r_rdata;
   assign o_dbg_rdata = r_mem[i_dbg_raddr];

endmodule

// File: rtl/stalled_single_store_top.sv
// ----------------------------------------------------------------------------
// stalled_single_store_top
// HLS-style kernel with its own RAM. After reset it reads mem[SRC_ADDR],
// doubles it (overflow dropped), writes mem[DST_ADDR] and pulses valid once,
// then halts until the next reset. A global stall freezes the FSM and
// suppresses kernel memory requests; the RAM and debug ports stay live.
// Ports:
//   clk               in   clock
//   rst               in   asynchronous active-low reset (FSM/valid only)
//   stall             in   1 = hold kernel state, no kernel memory requests
//   valid             out  one-cycle completion pulse
//   debug_addr        in   debug read address
//   debug_data        out  mem[debug_addr], combinational
//   debug_write_addr  in   debug write address
//   debug_write_data  in   debug write data
//   debug_write_en    in   debug write strobe
// ----------------------------------------------------------------------------
module stalled_single_store_top
   import ss_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned SRC_ADDR = SRC_ADDR_DEF,
   parameter int unsigned DST_ADDR = DST_ADDR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   output logic              valid,
   input  logic [ADDR_W-1:0] debug_addr,
   output logic [DATA_W-1:0] debug_data,
   input  logic [ADDR_W-1:0] debug_write_addr,
   input  logic [DATA_W-1:0] debug_write_data,
   input  logic              debug_write_en
);

   localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_ADDR);
   localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_ADDR);

   state_t            r_state;
   state_t            w_next;
   logic              r_valid;
   logic              w_valid_next;
   logic              w_ren;
   logic              w_wen;
   logic [DATA_W-1:0] w_rdata;
   logic [DATA_W-1:0] w_wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_READ;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         r_valid <= w_valid_next;
      end
   end

   // valid is registered: it is set on the edge that leaves S_DONE, so the
   // pulse appears on the 4th un-stalled posedge after reset release.
   always_comb begin
      w_next       = r_state;
      w_ren        = 1'b0;
      w_wen        = 1'b0;
      w_valid_next = 1'b0;
      if (!stall) begin
         case (r_state)
            S_READ: begin
               w_ren  = 1'b1;
               w_next = S_WAIT;
            end
            S_WAIT: begin
               w_next = S_WRITE;
            end
            S_WRITE: begin
               w_wen  = 1'b1;
               w_next = S_DONE;
            end
            S_DONE: begin
               w_valid_next = 1'b1;
               w_next       = S_HALT;
            end
            S_HALT: begin
               w_next = S_HALT;
            end
            default: begin
               w_next = S_READ;
            end
         endcase
      end
   end

   assign w_wdata = w_rdata << 1;
   assign valid   = r_valid;

   ss_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk         (clk),
      .i_ren       (w_ren),
      .i_raddr     (SRC_A),
      .o_rdata     (w_rdata),
      .i_wen       (w_wen),
      .i_waddr     (DST_A),
      .i_wdata     (w_wdata),
      .i_dbg_raddr (debug_addr),
      .o_dbg_rdata (debug_data),
      .i_dbg_wen   (debug_write_en),
      .i_dbg_waddr (debug_write_addr),
      .i_dbg_wdata (debug_write_data)
   );

endmodule

// File: tb/tb_stalled_single_store_top.sv
// ----------------------------------------------------------------------------
// tb_stalled_single_store_top
// Self-checking bench for stalled_single_store_top.
// ----------------------------------------------------------------------------
module tb_stalled_single_store_top;

   localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        valid;
   logic [4:0]  debug_addr = '0;
   logic [31:0] debug_data;
   logic [4:0]  debug_write_addr = '0;
   logic [31:0] debug_write_data = '0;
   logic        debug_write_en = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];

   typedef struct {
      logic [31:0] src;
      int          stall_start;
      int          stall_len;
      int          col_cycle;
      logic [31:0] col_data;
      int          exp_cycle;
      logic [31:0] exp_mem0;
   } vec_t;

   vec_t vecs[7];

   stalled_single_store_top dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .valid            (valid),
      .debug_addr       (debug_addr),
      .debug_data       (debug_data),
      .debug_write_addr (debug_write_addr),
      .debug_write_data (debug_write_data),
      .debug_write_en   (debug_write_en)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      debug_write_en   = 1'b1;
      debug_write_addr = a;
      debug_write_data = d;
      @(negedge clk);
      debug_write_en   = 1'b0;
   endtask

   task automatic dbg_read(input logic [4:0] a, output logic [31:0] d);
      debug_addr = a;
      #1;
      d = debug_data;
   endtask

   // Releases reset at a negedge and runs 14 posedges, checking the valid
   // pulse against the scoreboard and the final memory contents.
   task automatic release_and_run(input vec_t v, input string tag);
      logic [31:0] rd;
      int          got;
      rst = 1'b1;
      exp_q.push_back(v.exp_cycle);
      for (int cyc = 1; cyc <= 14; cyc++) begin
         stall = (cyc >= v.stall_start) && (cyc < v.stall_start + v.stall_len);
         if (cyc == v.col_cycle) begin
            debug_write_en   = 1'b1;
            debug_write_addr = 5'd0;
            debug_write_data = v.col_data;
         end
         @(posedge clk);
         @(negedge clk);
         debug_write_en = 1'b0;
         if (valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL %s spurious_valid: valid=1 at cycle %0d, required 0", tag, cyc);
            end else begin
               got = exp_q.pop_front();
               check32({tag, " valid_cycle"}, 32'(cyc), 32'(got));
            end
         end
      end
      stall = 1'b0;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s valid_timeout: no valid within 14 cycles, required at cycle %0d",
                  tag, exp_q[0]);
         exp_q.delete();
      end
      dbg_read(5'd0, rd);
      check32({tag, " mem0"}, rd, v.exp_mem0);
      dbg_read(5'd1, rd);
      check32({tag, " mem1"}, rd, v.src);
   endtask

   task automatic run_vector(input vec_t v, input string tag);
      rst = 1'b0;
      stall = 1'b0;
      dbg_write(5'd1, v.src);
      dbg_write(5'd0, SENTINEL);
      check32({tag, " reset_valid"}, 32'(valid), 32'd0);
      release_and_run(v, tag);
   endtask

   initial begin
      logic [31:0] rd;
      vec_t        v;

      //           src            st  len col col_data      exp  mem0
      vecs[0] = '{32'd10,          0,  0,  0, 32'd0,          4, 32'd20};
      vecs[1] = '{32'd10,          3,  3,  0, 32'd0,          7, 32'd20};
      vecs[2] = '{32'h8000_0001,   0,  0,  0, 32'd0,          4, 32'h0000_0002};
      vecs[3] = '{32'd5,           1,  2,  0, 32'd0,          6, 32'd10};
      vecs[4] = '{32'd7,           0,  0,  3, 32'h0000_1234,  4, 32'h0000_1234};
      vecs[5] = '{32'hFFFF_FFFF,   4,  1,  0, 32'd0,          5, 32'hFFFF_FFFE};
      vecs[6] = '{32'd21,          5,  2,  0, 32'd0,          4, 32'd42};

      #1 rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_vector(vecs[i], $sformatf("vec%0d", i));

      // Reset asserted while in S_WAIT: valid drops, no write happens.
      rst = 1'b0;
      dbg_write(5'd1, 32'd3);
      dbg_write(5'd0, SENTINEL);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check32("midrst valid_in_reset", 32'(valid), 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check32("midrst valid_held", 32'(valid), 32'd0);
      dbg_read(5'd0, rd);
      check32("midrst no_write", rd, SENTINEL);
      v = '{32'd3, 0, 0, 0, 32'd0, 4, 32'd6};
      release_and_run(v, "midrst_rerun");

      // Reset after the write committed: RAM keeps the stored value.
      rst = 1'b0;
      dbg_write(5'd1, 32'd9);
      dbg_write(5'd0, SENTINEL);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check32("lateRst valid", 32'(valid), 32'd0);
      dbg_read(5'd0, rd);
      check32("lateRst mem0_kept", rd, 32'd18);
      dbg_write(5'd1, 32'd4);
      v = '{32'd4, 0, 0, 0, 32'd0, 4, 32'd8};
      release_and_run(v, "lateRst_rerun");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
